// File: rtl/tap_pkg.sv
// TAP state encoding plus the 1149.1 next-state and shortest-path navigation helpers
// used by the TMS driver.
package tap_pkg;

  typedef enum logic [3:0] {
    TAP_EX2DR = 4'h0,
    TAP_EX1DR = 4'h1,
    TAP_SHDR  = 4'h2,
    TAP_PSDR  = 4'h3,
    TAP_SELIR = 4'h4,
    TAP_UPDDR = 4'h5,
    TAP_CAPDR = 4'h6,
    TAP_SELDR = 4'h7,
    TAP_EX2IR = 4'h8,
    TAP_EX1IR = 4'h9,
    TAP_SHIR  = 4'hA,
    TAP_PSIR  = 4'hB,
    TAP_RTI   = 4'hC,
    TAP_UPDIR = 4'hD,
    TAP_CAPIR = 4'hE,
    TAP_TLR   = 4'hF
  } tap_state_t;

  localparam int unsigned TAP_INIT_ONES = 5;

  function automatic tap_state_t tap_step(input tap_state_t s, input logic tms);
    tap_state_t n;
    case (s)
      TAP_TLR:   n = tms ? TAP_TLR   : TAP_RTI;
      TAP_RTI:   n = tms ? TAP_SELDR : TAP_RTI;
      TAP_SELDR: n = tms ? TAP_SELIR : TAP_CAPDR;
      TAP_CAPDR: n = tms ? TAP_EX1DR : TAP_SHDR;
      TAP_SHDR:  n = tms ? TAP_EX1DR : TAP_SHDR;
      TAP_EX1DR: n = tms ? TAP_UPDDR : TAP_PSDR;
      TAP_PSDR:  n = tms ? TAP_EX2DR : TAP_PSDR;
      TAP_EX2DR: n = tms ? TAP_UPDDR : TAP_SHDR;
      TAP_UPDDR: n = tms ? TAP_SELDR : TAP_RTI;
      TAP_SELIR: n = tms ? TAP_TLR   : TAP_CAPIR;
      TAP_CAPIR: n = tms ? TAP_EX1IR : TAP_SHIR;
      TAP_SHIR:  n = tms ? TAP_EX1IR : TAP_SHIR;
      TAP_EX1IR: n = tms ? TAP_UPDIR : TAP_PSIR;
      TAP_PSIR:  n = tms ? TAP_EX2IR : TAP_PSIR;
      TAP_EX2IR: n = tms ? TAP_UPDIR : TAP_SHIR;
      TAP_UPDIR: n = tms ? TAP_SELDR : TAP_RTI;
      default:   n = TAP_TLR;
    endcase
    return n;
  endfunction

  function automatic logic tap_is_stable(input tap_state_t s);
    return s inside {TAP_TLR, TAP_RTI, TAP_SHDR, TAP_PSDR, TAP_SHIR, TAP_PSIR};
  endfunction

  function automatic logic tap_hold(input tap_state_t s);
    return (s == TAP_TLR);
  endfunction

  // Per target, the states whose shortest path starts with TMS=0; all others start with 1.
  // When s == t the result is the hold bit of t.
  function automatic logic tap_nav(input tap_state_t s, input tap_state_t t);
    logic b;
    case (t)
      TAP_TLR:  b = 1'b1;
      TAP_RTI:  b = !(s inside {TAP_TLR, TAP_RTI, TAP_UPDDR, TAP_UPDIR});
      TAP_SHDR: b = !(s inside {TAP_TLR, TAP_SELDR, TAP_CAPDR, TAP_SHDR, TAP_EX1DR, TAP_EX2DR});
      TAP_PSDR: b = !(s inside {TAP_TLR, TAP_SELDR, TAP_EX1DR, TAP_PSDR, TAP_EX2DR});
      TAP_SHIR: b = !(s inside {TAP_TLR, TAP_SELIR, TAP_CAPIR, TAP_SHIR, TAP_EX1IR, TAP_EX2IR});
      TAP_PSIR: b = !(s inside {TAP_TLR, TAP_SELIR, TAP_EX1IR, TAP_PSIR, TAP_EX2IR});
      default:  b = 1'b1;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/tap_obs_check.sv
// Compares the TAP observation bus against the shadow state delayed by OBS_LAT cycles;
// any difference latches a sticky mismatch flag until reset.
module tap_obs_check import tap_pkg::*; #(
  parameter int unsigned OBS_LAT  = 1,
  parameter logic        CHECK_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       active,
  input  logic [3:0] shadow,
  input  logic [3:0] state_obs,
  output logic       mismatch
);

  localparam int unsigned FW = $clog2(OBS_LAT + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(OBS_LAT);

  logic [3:0]    dly_d [OBS_LAT];
  logic [3:0]    dly_q [OBS_LAT];
  logic [FW-1:0] fill_d, fill_q;
  logic          mismatch_d, mismatch_q;

  always_comb begin
    dly_d = dly_q;
    dly_d[0] = shadow;
    for (int i = 1; i < OBS_LAT; i++) dly_d[i] = dly_q[i-1];

    // The fill count restarts whenever INIT runs so stale pre-init states are never compared.
    fill_d = '0;
    if (active) fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;

    mismatch_d = mismatch_q;
    if ((CHECK_EN == 1'b1) && active && (fill_q == FILL_MAX) &&
        (state_obs != dly_q[OBS_LAT-1]))
      mismatch_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OBS_LAT; i++) dly_q[i] <= TAP_TLR;
      fill_q     <= '0;
      mismatch_q <= 1'b0;
    end else begin
      dly_q      <= dly_d;
      fill_q     <= fill_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign mismatch = mismatch_q;

endmodule

// File: rtl/tap_tms_driver.sv
// JTAG TMS initiator: walks the TAP along the shortest path to a requested stable state
// while tracking a shadow copy of the TAP state.
//
// state | meaning
// INIT  | TMS held at 1 so the TAP lands in TLR; shadow forced to TLR
// IDLE  | ready for a request; TMS holds the current stable state
// WALK  | one TMS bit per cycle toward the latched target
module tap_tms_driver import tap_pkg::*; #(
  parameter int unsigned OBS_LAT  = 1,
  parameter logic        CHECK_EN = 1'b1
) (
  input  logic       GCLK,
  input  logic       TRST_N,
  input  logic       req_valid,
  input  logic [3:0] req_target,
  output logic       req_ready,
  output logic       TMS_out,
  output logic [3:0] shadow_state,
  output logic       done,
  output logic       err_target,
  input  logic [3:0] state_obs,
  output logic       mismatch
);

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_WALK = 2'd2;

  logic [1:0] state_d, state_q;
  logic [2:0] init_cnt_d, init_cnt_q;
  tap_state_t shadow_d, shadow_q;
  tap_state_t target_d, target_q;
  logic       tms_d, tms_q;
  logic       done_d, done_q;
  logic       err_d, err_q;
  tap_state_t req_t;

  assign req_t = tap_state_t'(req_target);

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    shadow_d   = shadow_q;
    target_d   = target_q;
    tms_d      = tms_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_INIT: begin
        tms_d    = 1'b1;
        shadow_d = TAP_TLR;
        if (init_cnt_q == 3'(TAP_INIT_ONES)) state_d = ST_IDLE;
        else init_cnt_d = init_cnt_q + 3'd1;
      end
      ST_IDLE: begin
        tms_d = tap_hold(shadow_q);
        if (req_valid) begin
          if (!tap_is_stable(req_t)) begin
            err_d = 1'b1;
          end else if (req_t == shadow_q) begin
            done_d = 1'b1;
          end else begin
            target_d = req_t;
            tms_d    = tap_nav(shadow_q, req_t);
            state_d  = ST_WALK;
          end
        end
      end
      ST_WALK: begin
        // The TAP samples tms_q on this same edge, so the shadow advances in lockstep.
        shadow_d = tap_step(shadow_q, tms_q);
        tms_d    = tap_nav(shadow_d, target_q);
        if (shadow_d == target_q) begin
          done_d  = 1'b1;
          tms_d   = tap_hold(shadow_d);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge GCLK or negedge TRST_N) begin
    if (!TRST_N) begin
      state_q    <= ST_INIT;
      init_cnt_q <= 3'd0;
      shadow_q   <= TAP_TLR;
      target_q   <= TAP_TLR;
      tms_q      <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      shadow_q   <= shadow_d;
      target_q   <= target_d;
      tms_q      <= tms_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign TMS_out      = tms_q;
  assign shadow_state = shadow_q;
  assign done         = done_q;
  assign err_target   = err_q;

  tap_obs_check #(
    .OBS_LAT  (OBS_LAT),
    .CHECK_EN (CHECK_EN)
  ) u_obs_check (
    .clk       (GCLK),
    .rst_n     (TRST_N),
    .active    (state_q != ST_INIT),
    .shadow    (shadow_q),
    .state_obs (state_obs),
    .mismatch  (mismatch)
  );

endmodule

// File: tb/tb_tap_tms_driver.sv
// Bench for tap_tms_driver: a behavioural TAP with one cycle of observation latency,
// directed walk tables, corner sequences and randomized requests checked against a
// shortest-path search over the TAP transition table.
module tb_tap_tms_driver;

  logic       GCLK;
  logic       TRST_N;
  logic       req_valid;
  logic [3:0] req_target;
  logic       req_ready;
  logic       TMS_out;
  logic [3:0] shadow_state;
  logic       done;
  logic       err_target;
  logic [3:0] state_obs;
  logic       mismatch;

  tap_tms_driver #(.OBS_LAT(1), .CHECK_EN(1'b1)) dut (
    .GCLK         (GCLK),
    .TRST_N       (TRST_N),
    .req_valid    (req_valid),
    .req_target   (req_target),
    .req_ready    (req_ready),
    .TMS_out      (TMS_out),
    .shadow_state (shadow_state),
    .done         (done),
    .err_target   (err_target),
    .state_obs    (state_obs),
    .mismatch     (mismatch)
  );

  initial GCLK = 1'b0;
  always #5 GCLK = ~GCLK;

  // TAP transition table indexed by state encoding: next state for TMS=0 and TMS=1.
  localparam logic [3:0] NXT0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                                       4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
  localparam logic [3:0] NXT1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                                       4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};

  function automatic logic [3:0] nxt(input logic [3:0] s, input bit b);
    return b ? NXT1[s] : NXT0[s];
  endfunction

  function automatic bit tb_stable(input logic [3:0] s);
    return (s == 4'hF) || (s == 4'hC) || (s == 4'h2) || (s == 4'h3) || (s == 4'hA) || (s == 4'hB);
  endfunction

  // Behavioural TAP attached to TMS_out; its reset state is deliberately not TLR.
  logic [3:0] tap_q, obs_q, obs_flip;
  always_ff @(posedge GCLK or negedge TRST_N) begin
    if (!TRST_N) begin
      tap_q <= 4'h2;
      obs_q <= 4'h2;
    end else begin
      tap_q <= nxt(tap_q, TMS_out);
      obs_q <= tap_q;
    end
  end
  assign state_obs = obs_q ^ obs_flip;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] exp_sh;
  bit         mp_bits[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Shortest path by distance relaxation over the transition table.
  task automatic model_path(input logic [3:0] s, input logic [3:0] t);
    int d[16];
    logic [3:0] cur;
    mp_bits.delete();
    foreach (d[i]) d[i] = 99;
    d[t] = 0;
    repeat (16)
      for (int x = 0; x < 16; x++)
        for (int b = 0; b < 2; b++)
          if (d[nxt(4'(x), b[0])] + 1 < d[x]) d[x] = d[nxt(4'(x), b[0])] + 1;
    cur = s;
    for (int g = 0; g < 20 && cur != t; g++) begin
      bit bb;
      bb = (d[nxt(cur, 1'b0)] == d[cur] - 1) ? 1'b0 : 1'b1;
      mp_bits.push_back(bb);
      cur = nxt(cur, bb);
    end
  endtask

  // Issue one request at a negedge and follow it to completion; ends at a negedge.
  task automatic do_walk(input logic [3:0] tgt, input bit use_tbl, input int tbl_len,
                         input logic [7:0] tbl_bits, input string nm);
    bit bits[$];
    logic [3:0] sts[$];
    logic [3:0] s;
    if (tb_stable(tgt) && tgt != exp_sh) begin
      if (use_tbl) for (int i = 0; i < tbl_len; i++) bits.push_back(tbl_bits[tbl_len-1-i]);
      else begin
        model_path(exp_sh, tgt);
        bits = mp_bits;
      end
    end
    s = exp_sh;
    foreach (bits[i]) begin
      s = nxt(s, bits[i]);
      sts.push_back(s);
    end
    chk({nm, " ready_before"}, req_ready, 1);
    req_valid  = 1'b1;
    req_target = tgt;
    @(negedge GCLK);
    req_valid  = 1'b0;
    req_target = 4'($urandom_range(0, 15));
    if (!tb_stable(tgt)) begin
      chk({nm, " err"}, err_target, 1);
      chk({nm, " err_done"}, done, 0);
      chk({nm, " err_shadow"}, shadow_state, exp_sh);
      chk({nm, " err_tms"}, TMS_out, exp_sh == 4'hF);
      @(negedge GCLK);
      chk({nm, " err_pulse"}, err_target, 0);
      chk({nm, " err_shadow2"}, shadow_state, exp_sh);
    end else if (bits.size() == 0) begin
      chk({nm, " same_done"}, done, 1);
      chk({nm, " same_shadow"}, shadow_state, exp_sh);
      chk({nm, " same_tms"}, TMS_out, exp_sh == 4'hF);
      chk({nm, " same_err"}, err_target, 0);
    end else begin
      chk({nm, " tms0"}, TMS_out, bits[0]);
      chk({nm, " busy"}, req_ready, 0);
      chk({nm, " shadow0"}, shadow_state, exp_sh);
      chk({nm, " done0"}, done, 0);
      for (int i = 1; i <= bits.size(); i++) begin
        @(negedge GCLK);
        req_target = 4'($urandom_range(0, 15));
        chk({nm, " shadow"}, shadow_state, sts[i-1]);
        if (i < bits.size()) begin
          chk({nm, " tms"}, TMS_out, bits[i]);
          chk({nm, " done_early"}, done, 0);
        end else begin
          chk({nm, " done"}, done, 1);
          chk({nm, " ready_at_done"}, req_ready, 1);
          chk({nm, " tms_hold"}, TMS_out, tgt == 4'hF);
        end
      end
      exp_sh = tgt;
    end
  endtask

  task automatic init_check(input string nm);
    TRST_N = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge GCLK);
      chk({nm, " init_tms"}, TMS_out, 1);
      chk({nm, " init_ready"}, req_ready, 0);
    end
    @(negedge GCLK);
    chk({nm, " ready6"}, req_ready, 1);
    chk({nm, " shadow_tlr"}, shadow_state, 4'hF);
    chk({nm, " tms_tlr"}, TMS_out, 1);
    exp_sh = 4'hF;
  endtask

  typedef struct {
    logic [3:0] tgt;
    int         len;
    logic [7:0] bits;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{4'h2, 4, 8'b0100};
    vecs[1]  = '{4'hA, 6, 8'b111100};
    vecs[2]  = '{4'h2, 5, 8'b11100};
    vecs[3]  = '{4'h3, 2, 8'b10};
    vecs[4]  = '{4'h2, 2, 8'b10};
    vecs[5]  = '{4'hC, 3, 8'b110};
    vecs[6]  = '{4'h1, 0, 8'b0};
    vecs[7]  = '{4'hC, 0, 8'b0};
    vecs[8]  = '{4'hB, 5, 8'b11010};
    vecs[9]  = '{4'hF, 5, 8'b11111};
    vecs[10] = '{4'hF, 0, 8'b0};

    TRST_N = 1'b0;
    req_valid = 1'b0;
    req_target = 4'h0;
    obs_flip = 4'h0;
    exp_sh = 4'hF;
    repeat (3) @(negedge GCLK);
    chk("rst tms", TMS_out, 1);
    chk("rst shadow", shadow_state, 4'hF);
    chk("rst ready", req_ready, 0);
    chk("rst done", done, 0);
    chk("rst err", err_target, 0);
    chk("rst mismatch", mismatch, 0);

    init_check("boot");
    foreach (vecs[i]) do_walk(vecs[i].tgt, 1'b1, vecs[i].len, vecs[i].bits, $sformatf("vec%0d", i));
    chk("no_mismatch_directed", mismatch, 0);

    // Single-cycle corruption of the observation bus must latch mismatch.
    obs_flip = 4'h5;
    @(negedge GCLK);
    obs_flip = 4'h0;
    chk("mismatch_set", mismatch, 1);
    repeat (4) @(negedge GCLK);
    chk("mismatch_sticky", mismatch, 1);

    // Asynchronous reset in the middle of a walk.
    req_valid = 1'b1;
    req_target = 4'hA;
    @(negedge GCLK);
    req_valid = 1'b0;
    @(negedge GCLK);
    chk("pre_abort_shadow", shadow_state, 4'hC);
    #2 TRST_N = 1'b0;
    #1;
    chk("abort tms", TMS_out, 1);
    chk("abort shadow", shadow_state, 4'hF);
    chk("abort ready", req_ready, 0);
    chk("abort done", done, 0);
    chk("abort mismatch", mismatch, 0);
    @(negedge GCLK);
    init_check("rerun");

    for (int r = 0; r < 40; r++) begin
      logic [3:0] t;
      t = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) t = exp_sh;
      do_walk(t, 1'b0, 0, 8'h0, $sformatf("rnd%0d", r));
    end
    chk("no_mismatch_random", mismatch, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tap_tms_driver.md
# tap_tms_driver

- JTAG initiator that drives the TMS line of the TAP_route controller from a GCLK-domain request interface.
- Walks the TAP along the shortest legal path to a requested stable state and keeps a shadow copy of the TAP state.
- Optionally checks the TAP's 4-bit state observation outputs against that shadow copy.
- Used as the stimulus-side companion of TAP_route in qPALACE test setups and as an on-chip TAP master.

## Interface
- OBS_LAT, 1: GCLK cycles from shadow_state update to matching state_obs appearance.
- CHECK_EN, 1: 1 enables the state_obs comparison; 0 ties mismatch to 0.
- GCLK  in  1  single clock, rising-edge.
- TRST_N  in  1  reset, asynchronous assert, active-low.
- req_valid  in  1  walk request.
- req_target  in  4  requested TAP state, encoded per package.
- req_ready  out  1  block idle, request accepted on valid&&ready.
- TMS_out  out  1  registered TMS driven to TAP_route TMS_Pad.
- shadow_state  out  4  state the TAP is in after sampling the current TMS_out.
- done  out  1  one-cycle pulse: shadow_state reached target.
- err_target  out  1  one-cycle pulse: non-stable target rejected.
- state_obs  in  4  TAP observation bus, obs3..obs0.
- mismatch  out  1  sticky: state_obs differed from delayed shadow.

## Operation
- Encoding: TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PsDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PsIR=B, Ex2IR=8, UpdIR=D.
- Stable targets: TLR, RTI, ShDR, PsDR, ShIR, PsIR.
- Hold TMS: 1 for TLR, 0 for all other stable states.
- Control FSM:
  - INIT: TMS_out=1 for 5 cycles, shadow forced to TLR, then IDLE.
  - IDLE: req_ready=1; TMS_out = hold bit of shadow.
  - WALK: each edge, shadow <= step(shadow, TMS_out) and TMS_out <= nav(next shadow, target). On arrival, done pulses, TMS_out = hold bit, then back to IDLE.
- step() is the IEEE 1149.1 next-state function.
- nav(s,t) returns the first TMS bit of the shortest path s->t; for s==t it returns the hold bit.
- Request with a non-stable target: accepted, err_target pulses the next cycle, no TMS or shadow change, remains IDLE.
- Request with target == shadow: done pulses the next cycle, zero transitions.
- req_target is sampled only at acceptance; later changes are ignored until done.
- Check: state_obs is compared with shadow_state delayed OBS_LAT cycles.
  - Comparison is active in IDLE and WALK only, and only once the delay line is filled after INIT.
  - Any difference sets mismatch; only reset clears it.

## Timing
- Reset values:
  - TMS_out=1, shadow_state=F, req_ready=0, done=0, err_target=0, mismatch=0, FSM=INIT with counter 0.
- TRST_N assert mid-walk aborts immediately; the walk restarts from INIT on deassert.
- INIT lasts 5 cycles; req_ready rises on the 6th rising edge after deassert.
- Acceptance edge k: TMS_out takes the first path bit at edge k. After a path of N transitions, shadow_state==target after edge k+N, and done and req_ready are high in that same cycle.
- A new request accepted during the done cycle starts a walk back-to-back, with no idle gap.
- One TMS bit per GCLK; no gaps inside a walk.

## Structure
- Package tap_pkg holds:
  - tap_state_t enum with the encodings above;
  - functions tap_step(state, tms), tap_nav(state, target) and tap_is_stable(state);
  - constant TAP_INIT_ONES=5.
- Sub-module tap_obs_check holds the OBS_LAT delay line, the fill counter and the sticky comparator.
- The top holds the control FSM, the shadow register and the TMS register.

## Test plan
- Reset release, CHECK_EN=1, with TAP_route attached:
  - TMS_out=1 for 5 cycles and req_ready on cycle 6;
  - shadow=F; mismatch stays 0.
- Walk to ShDR (2) from TLR:
  - TMS sequence 0,1,0,0;
  - shadow passes C,7,6,2 and done after 4 cycles;
  - then the ShIR (A) target from ShDR gives 1,1,1,1,0,0 via 1,5,7,4,E,A.
- ShDR->PsDR gives 1,0; PsDR->ShDR gives 1,0; ShDR->RTI gives 1,1,0 with done after 3 cycles.
- Target Ex1DR (1) from RTI:
  - err_target pulses one cycle;
  - TMS_out holds 0 and shadow stays C.
- Target equal to the current state:
  - done the next cycle, no TMS change;
  - a back-to-back request in the done cycle is accepted with no gap.
- Error and reset cases:
  - Force state_obs to a wrong value for one cycle: mismatch sets and persists.
  - Assert TRST_N low mid-walk: outputs return to reset values asynchronously and INIT reruns.
